// File: rtl/dm_selftest.sv
// March-test engine for the data memory: 0-write up, r0/w1 up, r1/w0 down, r0 up.
// Owns the DM port while busy; stops on the first mismatch and reports its address.
`timescale 1ns/1ps
module dm_selftest #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              finish,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_M0, S_M1R, S_M1W, S_M2R, S_M2W, S_M3, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_pass;
  logic [ADDR_W-1:0] r_fail_addr;

  logic              w_read;
  logic [DATA_W-1:0] w_expect;
  logic              w_mismatch;
  logic              w_at_last;
  logic              w_at_first;

  always_comb begin
    w_read   = (r_state == S_M1R) || (r_state == S_M2R) || (r_state == S_M3);
    w_expect = (r_state == S_M2R) ? '1 : '0;
    w_mismatch = w_read && (mem_rdata != w_expect);
    w_at_last  = (r_addr == LAST_ADDR);
    w_at_first = (r_addr == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_pass      <= 1'b0;
      r_fail_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_M0;
            r_addr      <= '0;
            r_pass      <= 1'b1;
            r_fail_addr <= '0;
          end
        end
        S_DONE: begin
          if (!start) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
          end
        end
        default: begin
          // Entering DONE outranks an abort requested on the same edge.
          if (w_mismatch) begin
            r_state     <= S_DONE;
            r_pass      <= 1'b0;
            r_fail_addr <= r_addr;
          end else if (r_state == S_M3 && w_at_last) begin
            r_state <= S_DONE;
          end else if (!start) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
          end else begin
            case (r_state)
              S_M0: begin
                if (w_at_last) begin
                  r_state <= S_M1R;
                  r_addr  <= '0;
                end else begin
                  r_addr <= r_addr + 1'b1;
                end
              end
              S_M1R: r_state <= S_M1W;
              S_M1W: begin
                if (w_at_last) begin
                  r_state <= S_M2R;
                  r_addr  <= LAST_ADDR;
                end else begin
                  r_state <= S_M1R;
                  r_addr  <= r_addr + 1'b1;
                end
              end
              S_M2R: r_state <= S_M2W;
              S_M2W: begin
                if (w_at_first) begin
                  r_state <= S_M3;
                  r_addr  <= '0;
                end else begin
                  r_state <= S_M2R;
                  r_addr  <= r_addr - 1'b1;
                end
              end
              S_M3:    r_addr <= r_addr + 1'b1;
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    finish    = (r_state == S_DONE);
    mem_we    = (r_state == S_M0) || (r_state == S_M1W) || (r_state == S_M2W);
    mem_addr  = r_addr;
    mem_wdata = (r_state == S_M1W) ? '1 : '0;
    pass      = r_pass;
    fail_addr = r_fail_addr;
  end

endmodule

// File: tb/tb_dm_selftest.sv
// Bench for dm_selftest on an 8-word DM model with optional stuck-at and coupling faults.
// Expected DM writes are queued per scenario and popped by a write monitor.
`timescale 1ns/1ps
module tb_dm_selftest;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          finish, pass, busy, mem_we;
  logic [AW-1:0] fail_addr, mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [N];
  int            fault_mode = 0;
  logic [AW+DW-1:0] sb_q[$];
  int            errors = 0;
  int            checks = 0;

  dm_selftest #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .pass(pass),
    .fail_addr(fail_addr), .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Fault 1: bit 4 of word 5 stuck at 0. Fault 2: a write to word 2 forces word 3 to the complement.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= (fault_mode == 1 && mem_addr == 5) ? (mem_wdata & ~32'h10) : mem_wdata;
      if (fault_mode == 2 && mem_addr == 2) mem[3] <= ~mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      logic [AW+DW-1:0] exp_w;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL write_trace: unexpected write addr=%0d data=%h, none expected", mem_addr, mem_wdata);
      end else begin
        exp_w = sb_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_w) begin
          errors++;
          $display("FAIL write_trace: got addr=%0d data=%h expected addr=%0d data=%h",
                   mem_addr, mem_wdata, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
        end
      end
    end
  end

  task automatic push_writes(input logic [DW-1:0] d, input int first, input int last);
    int step = (last >= first) ? 1 : -1;
    for (int a = first; ; a += step) begin
      sb_q.push_back({a[AW-1:0], d});
      if (a == last) break;
    end
  endtask

  task automatic push_full();
    push_writes('0, 0, N-1);
    push_writes('1, 0, N-1);
    push_writes('0, N-1, 0);
  endtask

  // Counts edges after E0 until finish is seen; caller must already be just past E0.
  task automatic wait_finish(output int n);
    n = 0;
    while (!finish && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    checks++;
    if ({finish, pass, fail_addr, busy, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {finish, pass, fail_addr, busy, mem_we, mem_addr, mem_wdata});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_clean_run();
    int n;
    fault_mode = 0;
    push_full();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}}) begin
      errors++;
      $display("FAIL clean_first_cycle: got busy=%b we=%b addr=%0d expected busy=1 we=1 addr=0",
               busy, mem_we, mem_addr);
    end
    wait_finish(n);
    checks++;
    if (n !== 48) begin errors++; $display("FAIL clean_latency: got %0d expected 48", n); end
    checks++;
    if ({pass, fail_addr} !== {1'b1, {AW{1'b0}}}) begin
      errors++; $display("FAIL clean_result: got pass=%b addr=%0d expected pass=1 addr=0", pass, fail_addr);
    end
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL clean_trace_left: got %0d expected 0", sb_q.size()); end
  endtask

  task automatic test_no_restart();
    int bad = 0;
    int n;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy || !finish) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL hold_no_restart: got %0d bad cycles expected 0", bad); end
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (finish !== 1'b0) begin errors++; $display("FAIL finish_fall: got %b expected 0", finish); end
    push_full();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    wait_finish(n);
    checks++;
    if (n !== 48) begin errors++; $display("FAIL rerun_latency: got %0d expected 48", n); end
    checks++;
    if (pass !== 1'b1 || sb_q.size() !== 0) begin
      errors++; $display("FAIL rerun_result: got pass=%b left=%0d expected pass=1 left=0", pass, sb_q.size());
    end
    @(negedge clk) start = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_stuck_bit();
    fault_mode = 1;
    push_writes('0, 0, N-1);
    push_writes('1, 0, N-1);
    push_writes('0, N-1, N-2);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    repeat (28) @(posedge clk);
    #1;
    checks++;
    if (finish !== 1'b0) begin errors++; $display("FAIL stuck_early: got finish=%b expected 0", finish); end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({finish, pass, fail_addr} !== {1'b1, 1'b0, 3'd5}) begin
      errors++;
      $display("FAIL stuck_result: got finish=%b pass=%b addr=%0d expected finish=1 pass=0 addr=5",
               finish, pass, fail_addr);
    end
    @(posedge clk); #1;
    checks++;
    if ({finish, busy} !== 2'b00) begin
      errors++; $display("FAIL stuck_leave_done: got finish=%b busy=%b expected 0 0", finish, busy);
    end
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL stuck_trace_left: got %0d expected 0", sb_q.size()); end
    fault_mode = 0;
  endtask

  task automatic test_coupling();
    int n;
    fault_mode = 2;
    push_full();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    wait_finish(n);
    checks++;
    if (n !== 44) begin errors++; $display("FAIL coupling_latency: got %0d expected 44", n); end
    checks++;
    if ({pass, fail_addr} !== {1'b0, 3'd3}) begin
      errors++; $display("FAIL coupling_result: got pass=%b addr=%0d expected pass=0 addr=3", pass, fail_addr);
    end
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL coupling_trace_left: got %0d expected 0", sb_q.size()); end
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    fault_mode = 0;
  endtask

  task automatic test_abort();
    push_writes('0, 0, N-1);
    push_writes('1, 0, 0);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({finish, busy, mem_we} !== 3'b000) begin
      errors++; $display("FAIL abort_idle: got finish=%b busy=%b we=%b expected 0 0 0", finish, busy, mem_we);
    end
    checks++;
    if ({pass, fail_addr} !== '0) begin
      errors++; $display("FAIL abort_cleared: got pass=%b addr=%0d expected 0 0", pass, fail_addr);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL abort_trace_left: got %0d expected 0", sb_q.size()); end
  endtask

  task automatic test_async_reset();
    int n;
    push_writes('0, 0, N-1);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if ({mem_we, mem_wdata} !== {1'b1, {DW{1'b1}}}) begin
      errors++; $display("FAIL areset_in_m1w: got we=%b data=%h expected we=1 data=ffffffff", mem_we, mem_wdata);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({finish, pass, fail_addr, busy, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL areset_outputs: got %h expected 0",
               {finish, pass, fail_addr, busy, mem_we, mem_addr, mem_wdata});
    end
    @(posedge clk); #1;
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL areset_trace_left: got %0d expected 0", sb_q.size()); end
    push_full();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}}) begin
      errors++;
      $display("FAIL areset_restart: got busy=%b we=%b addr=%0d expected busy=1 we=1 addr=0",
               busy, mem_we, mem_addr);
    end
    wait_finish(n);
    checks++;
    if (n !== 48 || pass !== 1'b1) begin
      errors++; $display("FAIL areset_rerun: got edges=%0d pass=%b expected 48 1", n, pass);
    end
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL areset_rerun_left: got %0d expected 0", sb_q.size()); end
    @(negedge clk) start = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_no_restart();
    test_stuck_bit();
    test_coupling();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
